// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with control decode, bubble insertion and divide hold
// Busy is the registered HOLD state; upstream stages must freeze while it is high.
module id_ex_stage_reg #(
  parameter int DATA_W          = 32,
  parameter int REG_ADDR_W      = 5,
  parameter int OPCODE_W        = 6,
  parameter int FUNCT_W         = 6,
  parameter int DIV_LATENCY     = 4,
  parameter int FLUSH_ZERO_DATA = 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Flush,
  input  logic                  Stall_in,
  input  logic                  In_Valid,
  input  logic [DATA_W-1:0]     PC_Plus_4_in,
  input  logic [DATA_W-1:0]     ReadData1_in,
  input  logic [DATA_W-1:0]     ReadData2_in,
  input  logic [DATA_W-1:0]     SignExtend_in,
  input  logic [REG_ADDR_W-1:0] Rs_in,
  input  logic [REG_ADDR_W-1:0] Rt_in,
  input  logic [REG_ADDR_W-1:0] Rd_in,
  input  logic [OPCODE_W-1:0]   OpCode_in,
  input  logic [FUNCT_W-1:0]    Funct_in,
  output logic [DATA_W-1:0]     PC_Plus_4_out,
  output logic [DATA_W-1:0]     ReadData1_out,
  output logic [DATA_W-1:0]     ReadData2_out,
  output logic [DATA_W-1:0]     SignExtend_out,
  output logic [REG_ADDR_W-1:0] Rs_out,
  output logic [REG_ADDR_W-1:0] Rt_out,
  output logic [REG_ADDR_W-1:0] Rd_out,
  output logic [OPCODE_W-1:0]   OpCode_out,
  output logic                  Valid_out,
  output logic [1:0]            ALUOp,
  output logic                  RegDst,
  output logic                  ALUSrc,
  output logic                  RegWrite,
  output logic                  Branch,
  output logic                  IsDiv,
  output logic                  Illegal,
  output logic                  Busy
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
  localparam logic [FUNCT_W-1:0]  FN_DIV   = FUNCT_W'(6'b011010);
  localparam logic [3:0]          CNT_INIT = 4'(DIV_LATENCY - 1);
  localparam bit                  DIV_HOLDS = (DIV_LATENCY > 1);

  typedef enum logic {RUN, HOLD} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic                  w_load;

  logic [DATA_W-1:0]     r_pc4, r_rd1, r_rd2, r_sext;
  logic [REG_ADDR_W-1:0] r_rs, r_rt, r_rd;
  logic [OPCODE_W-1:0]   r_op;
  logic                  r_valid;
  logic [1:0]            r_alu_op;
  logic                  r_reg_dst, r_alu_src, r_reg_write, r_branch, r_is_div, r_illegal;

  logic [1:0]            w_alu_op;
  logic                  w_reg_dst, w_alu_src, w_reg_write, w_branch, w_is_div, w_illegal;

  // Controls are only generated for real instructions; a bubble decodes to all zeros.
  always_comb begin
    w_alu_op    = 2'b00;
    w_reg_dst   = 1'b0;
    w_alu_src   = 1'b0;
    w_reg_write = 1'b0;
    w_branch    = 1'b0;
    w_is_div    = 1'b0;
    w_illegal   = 1'b0;
    if (In_Valid) begin
      case (OpCode_in)
        OP_ADDI: begin
          w_alu_op    = 2'b01;
          w_alu_src   = 1'b1;
          w_reg_write = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          w_alu_op = 2'b11;
          w_branch = 1'b1;
        end
        OP_RTYPE: begin
          w_alu_op    = 2'b10;
          w_reg_dst   = 1'b1;
          w_reg_write = 1'b1;
          w_is_div    = (Funct_in == FN_DIV);
        end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  // HOLD counts down regardless of Stall_in; Flush aborts it.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    if (Flush) begin
      w_state_next = RUN;
      w_cnt_next   = 4'd0;
    end else if (r_state == HOLD) begin
      if (r_cnt == 4'd1) begin
        w_state_next = RUN;
        w_cnt_next   = 4'd0;
      end else begin
        w_cnt_next = r_cnt - 4'd1;
      end
    end else if (!Stall_in) begin
      w_load = 1'b1;
      if (w_is_div && DIV_HOLDS) begin
        w_state_next = HOLD;
        w_cnt_next   = CNT_INIT;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_pc4       <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_sext      <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_op        <= '0;
      r_valid     <= 1'b0;
      r_alu_op    <= 2'b00;
      r_reg_dst   <= 1'b0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_branch    <= 1'b0;
      r_is_div    <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (Flush) begin
      r_valid     <= 1'b0;
      r_alu_op    <= 2'b00;
      r_reg_dst   <= 1'b0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_branch    <= 1'b0;
      r_is_div    <= 1'b0;
      r_illegal   <= 1'b0;
      if (FLUSH_ZERO_DATA != 0) begin
        r_pc4  <= '0;
        r_rd1  <= '0;
        r_rd2  <= '0;
        r_sext <= '0;
        r_rs   <= '0;
        r_rt   <= '0;
        r_rd   <= '0;
        r_op   <= '0;
      end
    end else if (w_load) begin
      r_pc4       <= PC_Plus_4_in;
      r_rd1       <= ReadData1_in;
      r_rd2       <= ReadData2_in;
      r_sext      <= SignExtend_in;
      r_rs        <= Rs_in;
      r_rt        <= Rt_in;
      r_rd        <= Rd_in;
      r_op        <= OpCode_in;
      r_valid     <= In_Valid;
      r_alu_op    <= w_alu_op;
      r_reg_dst   <= w_reg_dst;
      r_alu_src   <= w_alu_src;
      r_reg_write <= w_reg_write;
      r_branch    <= w_branch;
      r_is_div    <= w_is_div;
      r_illegal   <= w_illegal;
    end
  end

  assign PC_Plus_4_out  = r_pc4;
  assign ReadData1_out  = r_rd1;
  assign ReadData2_out  = r_rd2;
  assign SignExtend_out = r_sext;
  assign Rs_out         = r_rs;
  assign Rt_out         = r_rt;
  assign Rd_out         = r_rd;
  assign OpCode_out     = r_op;
  assign Valid_out      = r_valid;
  assign ALUOp          = r_alu_op;
  assign RegDst         = r_reg_dst;
  assign ALUSrc         = r_alu_src;
  assign RegWrite       = r_reg_write;
  assign Branch         = r_branch;
  assign IsDiv          = r_is_div;
  assign Illegal        = r_illegal;
  assign Busy           = (r_state == HOLD);

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - directed self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

  logic        Clk = 1'b0;
  logic        Reset_n, Flush, Stall_in, In_Valid;
  logic [31:0] pc4_i, rd1_i, rd2_i, sext_i;
  logic [4:0]  rs_i, rt_i, rd_i;
  logic [5:0]  op_i, fn_i;

  logic [31:0] pc4_o, rd1_o, rd2_o, sext_o;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic [5:0]  op_o;
  logic        valid_o, reg_dst, alu_src, reg_write, branch, is_div, illegal, busy;
  logic [1:0]  alu_op;

  logic [31:0] d1_pc4, d1_rd1, d1_rd2, d1_sext;
  logic [4:0]  d1_rs, d1_rt, d1_rd;
  logic [5:0]  d1_op;
  logic        d1_valid, d1_reg_dst, d1_alu_src, d1_reg_write, d1_branch, d1_is_div, d1_illegal, d1_busy;
  logic [1:0]  d1_alu_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  id_ex_stage_reg #(.DIV_LATENCY(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .Stall_in(Stall_in), .In_Valid(In_Valid),
    .PC_Plus_4_in(pc4_i), .ReadData1_in(rd1_i), .ReadData2_in(rd2_i), .SignExtend_in(sext_i),
    .Rs_in(rs_i), .Rt_in(rt_i), .Rd_in(rd_i), .OpCode_in(op_i), .Funct_in(fn_i),
    .PC_Plus_4_out(pc4_o), .ReadData1_out(rd1_o), .ReadData2_out(rd2_o), .SignExtend_out(sext_o),
    .Rs_out(rs_o), .Rt_out(rt_o), .Rd_out(rd_o), .OpCode_out(op_o), .Valid_out(valid_o),
    .ALUOp(alu_op), .RegDst(reg_dst), .ALUSrc(alu_src), .RegWrite(reg_write), .Branch(branch),
    .IsDiv(is_div), .Illegal(illegal), .Busy(busy)
  );

  id_ex_stage_reg #(.DIV_LATENCY(1)) dut_l1 (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .Stall_in(Stall_in), .In_Valid(In_Valid),
    .PC_Plus_4_in(pc4_i), .ReadData1_in(rd1_i), .ReadData2_in(rd2_i), .SignExtend_in(sext_i),
    .Rs_in(rs_i), .Rt_in(rt_i), .Rd_in(rd_i), .OpCode_in(op_i), .Funct_in(fn_i),
    .PC_Plus_4_out(d1_pc4), .ReadData1_out(d1_rd1), .ReadData2_out(d1_rd2), .SignExtend_out(d1_sext),
    .Rs_out(d1_rs), .Rt_out(d1_rt), .Rd_out(d1_rd), .OpCode_out(d1_op), .Valid_out(d1_valid),
    .ALUOp(d1_alu_op), .RegDst(d1_reg_dst), .ALUSrc(d1_alu_src), .RegWrite(d1_reg_write), .Branch(d1_branch),
    .IsDiv(d1_is_div), .Illegal(d1_illegal), .Busy(d1_busy)
  );

  // Control bundle: {Valid, ALUOp[1:0], RegDst, ALUSrc, RegWrite, Branch, IsDiv, Illegal, Busy}
  function automatic logic [9:0] ctl();
    return {valid_o, alu_op, reg_dst, alu_src, reg_write, branch, is_div, illegal, busy};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic [31:0] pc);
    In_Valid = v;
    op_i     = op;
    fn_i     = fn;
    pc4_i    = pc;
    rd1_i    = pc + 32'd1;
    rd2_i    = pc + 32'd2;
    sext_i   = pc + 32'd3;
    rs_i     = pc[4:0];
    rt_i     = pc[4:0] ^ 5'h1f;
    rd_i     = pc[4:0] + 5'd3;
  endtask

  initial begin
    Reset_n = 1'b0; Flush = 1'b0; Stall_in = 1'b0;
    drive(1'b1, 6'b001000, 6'd0, 32'h55);
    tick(); tick();
    check("rst_ctl",  {54'd0, ctl()}, 64'd0);
    check("rst_data", {pc4_o, rd1_o}, 64'd0);
    check("rst_spec", {rd2_o, sext_o}, 64'd0);
    check("rst_regs", {rs_o, rt_o, rd_o, op_o}, 64'd0);

    // ADDI load, first edge after reset release
    Reset_n = 1'b1;
    drive(1'b1, 6'b001000, 6'd0, 32'd100);
    rd1_i = 32'd5; sext_i = 32'd7;
    tick();
    check("addi_ctl",  {54'd0, ctl()}, {54'd0, 10'b1_01_0_1_1_0_0_0_0});
    check("addi_pc",   pc4_o, 32'd100);
    check("addi_rd1",  rd1_o, 32'd5);
    check("addi_sext", sext_o, 32'd7);
    check("addi_regs", {rs_o, rt_o, rd_o, op_o}, {5'd4, 5'd27, 5'd7, 6'b001000});

    // BEQ then 3 stalled cycles with changing inputs
    drive(1'b1, 6'b000100, 6'd0, 32'd200);
    tick();
    check("beq_ctl", {54'd0, ctl()}, {54'd0, 10'b1_11_0_0_0_1_0_0_0});
    Stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'b001000, 6'd0, 32'd300 + 32'(i));
      tick();
      check("stall_pc",  pc4_o, 32'd200);
      check("stall_ctl", {54'd0, ctl()}, {54'd0, 10'b1_11_0_0_0_1_0_0_0});
    end
    Flush = 1'b1;
    tick();
    check("flush_ctl",  {54'd0, ctl()}, 64'd0);
    check("flush_data", {pc4_o, rd1_o}, 64'd0);
    check("flush_op",   {rs_o, rt_o, rd_o, op_o}, 64'd0);
    Flush = 1'b0; Stall_in = 1'b0;

    // DIV with 4-cycle latency: Busy for 3 cycles, next load on 4th edge
    drive(1'b1, 6'b000000, 6'b011010, 32'd400);
    tick();
    check("div_ctl",    {54'd0, ctl()}, {54'd0, 10'b1_10_1_0_1_0_1_0_1});
    check("l1_div",     {62'd0, d1_is_div, d1_busy}, 64'd2);
    drive(1'b1, 6'b001000, 6'd0, 32'd500);
    tick();
    check("hold1_busy", {63'd0, busy}, 64'd1);
    check("hold1_pc",   pc4_o, 32'd400);
    check("l1_nobusy",  {63'd0, d1_busy}, 64'd0);
    tick();
    check("hold2_busy", {63'd0, busy}, 64'd1);
    check("hold2_pc",   pc4_o, 32'd400);
    tick();
    check("hold_exit",  {63'd0, busy}, 64'd0);
    check("hold3_pc",   pc4_o, 32'd400);
    check("hold3_div",  {63'd0, is_div}, 64'd1);
    tick();
    check("post_div_pc",  pc4_o, 32'd500);
    check("post_div_ctl", {54'd0, ctl()}, {54'd0, 10'b1_01_0_1_1_0_0_0_0});

    // Flush one cycle into a DIV hold
    drive(1'b1, 6'b000000, 6'b011010, 32'd600);
    tick();
    check("mdiv_busy0", {63'd0, busy}, 64'd1);
    drive(1'b1, 6'b001000, 6'd0, 32'd700);
    tick();
    check("mdiv_busy1", {63'd0, busy}, 64'd1);
    Flush = 1'b1;
    tick();
    check("mdiv_flush", {54'd0, ctl()}, 64'd0);
    check("mdiv_pc",    pc4_o, 32'd0);
    Flush = 1'b0;
    tick();
    check("mdiv_addi",  {54'd0, ctl()}, {54'd0, 10'b1_01_0_1_1_0_0_0_0});
    check("mdiv_pc2",   pc4_o, 32'd700);

    // Unknown opcode
    drive(1'b1, 6'b111111, 6'd0, 32'd800);
    tick();
    check("illegal_ctl", {54'd0, ctl()}, {54'd0, 10'b1_00_0_0_0_0_0_1_0});
    check("illegal_op",  {58'd0, op_o}, 64'h3f);

    // DIV encoding without In_Valid: bubble, no hold
    drive(1'b0, 6'b000000, 6'b011010, 32'd900);
    tick();
    check("inv_ctl", {54'd0, ctl()}, 64'd0);
    check("inv_pc",  pc4_o, 32'd900);
    tick();
    check("inv_busy", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline register for the multi-stage MIPS core.
- Captures decoded operands, register specifiers and opcode/funct from ID, generates EX control fields, and adds a valid bit, stall hold, flush-to-bubble, and a multi-cycle divide hold.
- The divide hold keeps a DIV in EX for DIV_LATENCY cycles and back-pressures ID/IF via Busy.
- Sits between the register file/sign-extender and the ALU/forwarding logic.

Parameters:
- DATA_W, 32, width of PC+4, read data and sign-extended immediate.
- REG_ADDR_W, 5, width of Rs/Rt/Rd specifiers.
- OPCODE_W, 6, opcode width; FUNCT_W, 6, funct width.
- DIV_LATENCY, 4, EX cycles occupied by a DIV; legal range 1..15.
- FLUSH_ZERO_DATA, 1, 1: flush clears data fields; 0: flush clears only Valid_out and controls.

Ports:
- Clk  in  1  pipeline clock; all state updates on posedge.
- Reset_n  in  1  synchronous active-low reset.
- Flush  in  1  insert bubble (branch taken / exception).
- Stall_in  in  1  hazard-unit hold request.
- In_Valid  in  1  ID stage holds a real instruction.
- PC_Plus_4_in  in  DATA_W.
- ReadData1_in, ReadData2_in  in  DATA_W each.
- SignExtend_in  in  DATA_W.
- Rs_in, Rt_in, Rd_in  in  REG_ADDR_W each; instr [25:21], [20:16], [15:11].
- OpCode_in  in  OPCODE_W.
- Funct_in  in  FUNCT_W.
- PC_Plus_4_out, ReadData1_out, ReadData2_out, SignExtend_out  out  DATA_W each.
- Rs_out, Rt_out, Rd_out  out  REG_ADDR_W each.
- OpCode_out  out  OPCODE_W.
- Valid_out  out  1.
- ALUOp  out  2.
- RegDst, ALUSrc, RegWrite, Branch, IsDiv, Illegal  out  1 each.
- Busy  out  1  DIV hold active; upstream must freeze.

Behaviour:
- Reset (Reset_n=0 at posedge):
  - All outputs are 0.
  - FSM goes to RUN; hold counter goes to 0.
  - Reset mid-DIV aborts the DIV.
- Priority at each posedge: Reset_n=0 > Flush > Busy (HOLD) > Stall_in > load.
- Flush:
  - Valid_out, ALUOp, RegDst, ALUSrc, RegWrite, Branch, IsDiv, Illegal are set to 0.
  - Data/specifier/opcode fields are set to 0 if FLUSH_ZERO_DATA=1, otherwise held.
  - FSM goes to RUN, counter to 0.
  - Busy is 0 from the next cycle.
- Stall_in=1 in RUN: all outputs hold their values.
- Load: all data fields copied from inputs; Valid_out<=In_Valid. Latency is 1 cycle.
- Decode (applied only when In_Valid=1; if In_Valid=0, all controls are 0):
  - 001000 ADDI: RegDst0, ALUOp01, ALUSrc1, RegWrite1, Branch0.
  - 000100 BEQ and 000101 BNE: RegDst0, ALUOp11, ALUSrc0, RegWrite0, Branch1.
  - 000000 R-type: RegDst1, ALUOp10, ALUSrc0, RegWrite1.
  - R-type with Funct_in=011010 (DIV) additionally sets IsDiv=1.
  - Any other opcode: all controls 0, Illegal=1.
- FSM RUN/HOLD:
  - Entry: a load with In_Valid=1, IsDiv decode and DIV_LATENCY>1 goes to HOLD and sets counter<=DIV_LATENCY-1.
  - In HOLD: Busy=1 (registered: equals state==HOLD), outputs held, counter decrements every cycle regardless of Stall_in.
  - Exit: counter==1 at a posedge gives HOLD->RUN and counter<=0. Busy is therefore high for exactly DIV_LATENCY-1 cycles.
  - DIV_LATENCY=1: no HOLD is ever entered.
  - Stall_in=1 on the exit cycle: FSM still returns to RUN, and the register then holds per Stall_in.
  - Back-to-back DIVs: the second DIV loads on the first RUN edge after HOLD and re-enters HOLD.
- Flush during HOLD aborts the DIV as described under Flush.
- Simultaneous Flush and Stall_in: Flush wins.

Test Plan:
- Reset: drive Reset_n=0 for 2 cycles with nonzero inputs -> every output 0, Busy 0. Release Reset_n -> next edge loads the inputs.
- ADDI load: OpCode_in=001000, In_Valid=1, ReadData1_in=5, SignExtend_in=7, PC_Plus_4_in=100 -> after 1 edge: Valid_out1, ALUSrc1, ALUOp01, RegWrite1, PC_Plus_4_out=100.
- Stall then flush: load BEQ, then Stall_in=1 for 3 cycles with new inputs -> outputs unchanged, Branch1. Then Flush=1 with Stall_in=1 -> Valid_out0, Branch0, data 0 (FLUSH_ZERO_DATA=1).
- DIV hold, DIV_LATENCY=4: load R-type with Funct=011010 -> IsDiv1; Busy=1 for exactly 3 cycles while outputs are held; next instruction (ADDI) loads on the 4th edge after the DIV load.
- Flush mid-DIV: after the DIV load and 1 HOLD cycle, pulse Flush -> Busy0 next cycle, Valid_out0; the following ADDI loads normally.
- Edge cases:
  - Unknown opcode 111111 with In_Valid=1 -> Illegal1, RegWrite0.
  - In_Valid=0 with DIV encoding -> Valid_out0, IsDiv0, no HOLD.
  - DIV_LATENCY=1 build: DIV never asserts Busy.
